mux_32_8: RTL and testbench
===========================

// Module: mux_32_8
// PURPOSE
// - Transmit-side serializer of the PCI PHY datapath: takes 32-bit words, emits them as a byte stream,
//   MSB byte first, 4 bytes per word, all on clk_4f.
// - Feeds the serial-parallel converter. The receive-side 8->32 demux reassembles the words.
// - Has a 1-word holding register, so back-to-back words stream with no idle cycles between bytes.
// PARAMETERS
// - WORD_W   32  input word width; must equal NBYTES*BYTE_W
// - BYTE_W    8  output symbol width
// - NBYTES    4  bytes per word (derived as WORD_W/BYTE_W; do not override)
// PORTS
// - clk_4f                input   1       byte-rate clock; the only clock
// - reset                 input   1       synchronous, active-low (0 = reset), sampled on posedge clk_4f
// - data_paralelo_32      input   WORD_W  word to transmit
// - valid_paralelo_32     input   1       data_paralelo_32 is valid
// - ready_mux_32_8        output  1       block accepts a word this cycle
// - data_mux_32_8         output  BYTE_W  serialized byte (registered)
// - valid_mux_32_8        output  1       data_mux_32_8 carries word data (registered)
// BEHAVIOUR
// - Reset (reset==0 at posedge):
//   - hold_valid=0, state=IDLE, cnt=0, shreg=0.
//   - data_mux_32_8=8'h00, valid_mux_32_8=0. Any partial word is discarded.
// - Handshake:
//   - ready_mux_32_8 = reset & ~hold_valid (combinational from registers).
//   - A word is accepted when valid_paralelo_32 & ready_mux_32_8 at posedge.
//   - An accepted word goes into hold; hold_valid is set.
//   - valid_paralelo_32 while not ready is ignored. The source must hold the word.
// - FSM states:
//   - IDLE: shifter empty.
//   - SEND: cnt = index (0..3) of the byte currently on the output.
// - Load condition = (state==IDLE) | (state==SEND & cnt==NBYTES-1). When it is true at posedge:
//   - If hold_valid:
//     - data_mux_32_8 <= hold[31:24]; shreg <= hold<<8
//     - cnt <= 0; state <= SEND; valid_mux_32_8 <= 1; hold_valid <= 0
//   - Else:
//     - state <= IDLE; valid_mux_32_8 <= 0; data_mux_32_8 <= idle byte (see CONFIGURATION)
// - Otherwise (SEND, cnt<3):
//   - data_mux_32_8 <= shreg[31:24]; shreg <= shreg<<8; cnt <= cnt+1; valid_mux_32_8 stays 1.
// - Hold does not accept and unload in the same edge. ready is low whenever hold is full.
// - Latency:
//   - Word accepted at edge E0 with IDLE state: byte0 visible after E1, byte3 after E4.
//   - Word accepted mid-SEND: byte0 follows the previous byte3 on the very next edge.
// - Throughput: 1 word per 4 clk_4f. Continuous valid input produces unbroken valid_mux_32_8=1.
// - Byte order: bits 31:24, 23:16, 15:8, 7:0. This matches the receiver, which shifts in with the MSB byte first.
// - Deasserting valid_paralelo_32 never truncates a word in flight. All 4 bytes always go out.
// - Reset asserted mid-word: the output goes to 0/0 on the same edge and the hold contents are lost.
// CONFIGURATION
// - `MUX_32_8_IDLE_EN defined:
//   - In IDLE outside reset, data_mux_32_8 = 8'hBC (COM idle symbol), with valid_mux_32_8=0.
//   - Reset value is still 8'h00.
// - Not defined: the idle byte is 8'h00.
// - Handshake, timing and valid behaviour are identical in both builds.
// STRUCTURE
// - Package pci_phy_pkg holds:
//   - constants WORD_W=32, BYTE_W=8, NBYTES=4, IDLE_SYM=8'hBC
//   - state encoding IDLE=1'b0, SEND=1'b1
//   - the shared byte-counter width CNT_W=2
// - Sub-module mux_32_8_shifter: shreg, cnt and the output registers, with load/shift inputs and a last_byte flag.
// - The top level keeps the hold register, the ready logic and the FSM.
// TESTING
// - Reset test: hold reset=0 for 3 cycles with valid=1.
//   - Expect data=00, valid_out=0 and ready=0 throughout.
//   - After release, expect ready=1 on the first cycle.
// - Single word: send 32'hDEADBEEF at E0 from IDLE.
//   - Expect bytes DE,AD,BE,EF after E1..E4 with valid_out=1.
//   - Then valid_out=0 and data 00, or BC with IDLE_EN.
// - Back-to-back: drive 32'h01020304, 32'hA0B0C0D0, 32'h11223344 with valid held high.
//   - Expect 12 contiguous valid bytes in order with no gaps.
//   - ready pulses once per 4 cycles.
// - Backpressure: keep valid high with changing data while ready=0.
//   - Only words sampled when ready=1 appear on the output. None are duplicated and none are dropped.
// - Mid-word reset: assert reset at byte 2 of 32'hCAFEF00D.
//   - Output is 00/0 on that edge.
//   - After release, the next word 32'h12345678 serializes cleanly.
// - Scoreboard round-trip: random words with random valid gaps through mux_32_8 into the 8->32 demux (1000 words).
//   - The reassembled words match the sent words in order.

Source files
------------

// File: rtl/pci_phy_pkg.sv
// Shared constants and state encoding for the PCI PHY transmit datapath.
package pci_phy_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int NBYTES = 4;
  localparam int CNT_W  = 2;

  localparam logic [7:0] IDLE_SYM = 8'hBC;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/mux_32_8_shifter.sv
// Byte shifter for mux_32_8: shift register, byte counter and registered outputs.
// MUX_32_8_IDLE_EN selects the COM symbol as the idle byte instead of 8'h00.
module mux_32_8_shifter
  import pci_phy_pkg::*;
#(
  parameter int WORD_W = pci_phy_pkg::WORD_W,
  parameter int BYTE_W = pci_phy_pkg::BYTE_W
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic              idle,
  input  logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              last_byte
);

  localparam int NBYTES = WORD_W / BYTE_W;

`ifdef MUX_32_8_IDLE_EN
  localparam logic [BYTE_W-1:0] IDLE_BYTE = BYTE_W'(IDLE_SYM);
`else
  localparam logic [BYTE_W-1:0] IDLE_BYTE = '0;
`endif

  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      shreg     <= '0;
      cnt       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (load) begin
      data_out  <= word[WORD_W-1 -: BYTE_W];
      shreg     <= word << BYTE_W;
      cnt       <= '0;
      valid_out <= 1'b1;
    end else if (shift) begin
      data_out  <= shreg[WORD_W-1 -: BYTE_W];
      shreg     <= shreg << BYTE_W;
      cnt       <= cnt + CNT_W'(1);
    end else if (idle) begin
      data_out  <= IDLE_BYTE;
      valid_out <= 1'b0;
    end
  end

  assign last_byte = (cnt == CNT_W'(NBYTES - 1));

endmodule

// File: rtl/mux_32_8.sv
// 32->8 transmit serializer with a one-word holding register, MSB byte first.
// Build option MUX_32_8_IDLE_EN: drive the COM idle symbol while idle.
//
// state | meaning
// IDLE  | shifter empty, output idle byte with valid low
// SEND  | shifter presenting byte cnt (0..3) of the current word
module mux_32_8
  import pci_phy_pkg::*;
#(
  parameter int WORD_W = pci_phy_pkg::WORD_W,
  parameter int BYTE_W = pci_phy_pkg::BYTE_W
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_paralelo_32,
  input  logic              valid_paralelo_32,
  output logic              ready_mux_32_8,
  output logic [BYTE_W-1:0] data_mux_32_8,
  output logic              valid_mux_32_8
);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] hold;
  logic              hold_valid;
  logic              accept;
  logic              load_cond;
  logic              load;
  logic              shift;
  logic              go_idle;
  logic              last_byte;

  assign ready_mux_32_8 = reset & ~hold_valid;
  assign accept         = valid_paralelo_32 & ready_mux_32_8;

  // accept needs hold empty and load needs it full, so they never collide
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold       <= data_paralelo_32;
      hold_valid <= 1'b1;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    go_idle   = 1'b0;
    load_cond = (state == IDLE) | ((state == SEND) & last_byte);
    if (load_cond) begin
      if (hold_valid) begin
        load      = 1'b1;
        state_nxt = SEND;
      end else begin
        go_idle   = 1'b1;
        state_nxt = IDLE;
      end
    end else begin
      shift = 1'b1;
    end
  end

  mux_32_8_shifter #(
    .WORD_W(WORD_W),
    .BYTE_W(BYTE_W)
  ) u_shifter (
    .clk_4f   (clk_4f),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .idle     (go_idle),
    .word     (hold),
    .data_out (data_mux_32_8),
    .valid_out(valid_mux_32_8),
    .last_byte(last_byte)
  );

endmodule

// File: tb/tb_mux_32_8.sv
// Self-checking bench for mux_32_8 against a byte-stream reference model.
module tb_mux_32_8;

  logic        clk_4f;
  logic        reset;
  logic [31:0] data_paralelo_32;
  logic        valid_paralelo_32;
  logic        ready_mux_32_8;
  logic [7:0]  data_mux_32_8;
  logic        valid_mux_32_8;

  int n_tests;
  int n_fail;

`ifdef MUX_32_8_IDLE_EN
  localparam logic [7:0] EXP_IDLE = 8'hBC;
`else
  localparam logic [7:0] EXP_IDLE = 8'h00;
`endif

  mux_32_8 dut (
    .clk_4f           (clk_4f),
    .reset            (reset),
    .data_paralelo_32 (data_paralelo_32),
    .valid_paralelo_32(valid_paralelo_32),
    .ready_mux_32_8   (ready_mux_32_8),
    .data_mux_32_8    (data_mux_32_8),
    .valid_mux_32_8   (valid_mux_32_8)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    valid_paralelo_32 = 1'b1;
    data_paralelo_32 = $urandom;
    for (int i = 0; i < 3; i++) begin
      tick();
      data_paralelo_32 = $urandom;
      n_tests++;
      if (data_mux_32_8 !== 8'h00 || valid_mux_32_8 !== 1'b0 || ready_mux_32_8 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: data=%h valid=%b ready=%b, want 00/0/0",
                 i, data_mux_32_8, valid_mux_32_8, ready_mux_32_8);
      end
    end
    valid_paralelo_32 = 1'b0;
    reset = 1'b1;
    #1;
    n_tests++;
    if (ready_mux_32_8 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: ready=%b, want 1", ready_mux_32_8);
    end
    tick();
    n_tests++;
    if (valid_mux_32_8 !== 1'b0 || data_mux_32_8 !== EXP_IDLE) begin
      n_fail++;
      $display("FAIL reset_idle: data=%h valid=%b, want %h/0", data_mux_32_8, valid_mux_32_8, EXP_IDLE);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    w = 32'hDEADBEEF;
    data_paralelo_32 = w;
    valid_paralelo_32 = 1'b1;
    tick();
    valid_paralelo_32 = 1'b0;
    data_paralelo_32 = $urandom;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (valid_mux_32_8 !== 1'b1 || data_mux_32_8 !== w[31-8*k -: 8]) begin
        n_fail++;
        $display("FAIL single_byte%0d: data=%h valid=%b, want %h/1",
                 k, data_mux_32_8, valid_mux_32_8, w[31-8*k -: 8]);
      end
    end
    tick();
    n_tests++;
    if (valid_mux_32_8 !== 1'b0 || data_mux_32_8 !== EXP_IDLE) begin
      n_fail++;
      $display("FAIL single_idle: data=%h valid=%b, want %h/0", data_mux_32_8, valid_mux_32_8, EXP_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    logic [7:0]  exp_b [12];
    logic [7:0]  obs_d [32];
    logic        obs_v [32];
    int          acc_cyc [3];
    int          idx;
    int          first;
    words[0] = 32'h01020304;
    words[1] = 32'hA0B0C0D0;
    words[2] = 32'h11223344;
    for (int i = 0; i < 12; i++) exp_b[i] = words[i/4][31-8*(i%4) -: 8];
    idx = 0;
    first = -1;
    data_paralelo_32 = words[0];
    valid_paralelo_32 = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (valid_paralelo_32 && ready_mux_32_8) begin
        acc_cyc[idx] = c;
        idx++;
        tick();
        if (idx < 3) data_paralelo_32 = words[idx];
        else valid_paralelo_32 = 1'b0;
      end else begin
        tick();
      end
      obs_d[c] = data_mux_32_8;
      obs_v[c] = valid_mux_32_8;
      if (first < 0 && valid_mux_32_8) first = c;
    end
    n_tests++;
    if (idx != 3 || first < 0 || first > 19) begin
      n_fail++;
      $display("FAIL b2b_accepts: accepted=%0d first_valid=%0d, want 3 and stream start", idx, first);
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_tests++;
        if (obs_v[first+i] !== 1'b1 || obs_d[first+i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL b2b_byte%0d: data=%h valid=%b, want %h/1", i, obs_d[first+i], obs_v[first+i], exp_b[i]);
        end
      end
      n_tests++;
      if (obs_v[first+12] !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_end: valid=%b after 12 bytes, want 0", obs_v[first+12]);
      end
      n_tests++;
      if (acc_cyc[1] - acc_cyc[0] != 2 || acc_cyc[2] - acc_cyc[1] != 4) begin
        n_fail++;
        $display("FAIL b2b_ready_spacing: gaps=%0d,%0d, want 2,4",
                 acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q [$];
    logic [7:0] e;
    int         n_acc;
    int         n_bytes;
    n_acc = 0;
    n_bytes = 0;
    for (int c = 0; c < 72; c++) begin
      valid_paralelo_32 = (c < 60);
      data_paralelo_32 = $urandom;
      if (valid_paralelo_32 && ready_mux_32_8) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(data_paralelo_32[31-8*k -: 8]);
        n_acc++;
      end
      tick();
      if (valid_mux_32_8) begin
        n_bytes++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra_byte: got %h, want no byte", data_mux_32_8);
        end else begin
          e = exp_q.pop_front();
          if (data_mux_32_8 !== e) begin
            n_fail++;
            $display("FAIL bp_byte%0d: got %h, want %h", n_bytes - 1, data_mux_32_8, e);
          end
        end
      end
    end
    valid_paralelo_32 = 1'b0;
    n_tests++;
    if (exp_q.size() != 0 || n_bytes != 4 * n_acc || n_acc < 10) begin
      n_fail++;
      $display("FAIL bp_count: bytes=%0d accepted=%0d leftover=%0d, want 4*accepted and none left",
               n_bytes, n_acc, exp_q.size());
    end
  endtask

  task automatic test_mid_word_reset();
    logic [31:0] w;
    data_paralelo_32 = 32'hCAFEF00D;
    valid_paralelo_32 = 1'b1;
    tick();
    valid_paralelo_32 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (data_mux_32_8 !== 8'h00 || valid_mux_32_8 !== 1'b0 || ready_mux_32_8 !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_out: data=%h valid=%b ready=%b, want 00/0/0",
               data_mux_32_8, valid_mux_32_8, ready_mux_32_8);
    end
    reset = 1'b1;
    w = 32'h12345678;
    data_paralelo_32 = w;
    valid_paralelo_32 = 1'b1;
    #1;
    n_tests++;
    if (ready_mux_32_8 !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ready: ready=%b, want 1", ready_mux_32_8);
    end
    tick();
    valid_paralelo_32 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (valid_mux_32_8 !== 1'b1 || data_mux_32_8 !== w[31-8*k -: 8]) begin
        n_fail++;
        $display("FAIL midreset_byte%0d: data=%h valid=%b, want %h/1",
                 k, data_mux_32_8, valid_mux_32_8, w[31-8*k -: 8]);
      end
    end
    tick();
    n_tests++;
    if (valid_mux_32_8 !== 1'b0 || data_mux_32_8 !== EXP_IDLE) begin
      n_fail++;
      $display("FAIL midreset_idle: data=%h valid=%b, want %h/0", data_mux_32_8, valid_mux_32_8, EXP_IDLE);
    end
  endtask

  task automatic test_scoreboard();
    logic [31:0] sent_q [$];
    logic [31:0] asm;
    logic [31:0] e;
    int          sent;
    int          rcvd;
    int          nb;
    int          cyc;
    bit          pend;
    sent = 0;
    rcvd = 0;
    nb = 0;
    cyc = 0;
    pend = 1'b0;
    asm = '0;
    valid_paralelo_32 = 1'b0;
    while (rcvd < 1000 && cyc < 20000) begin
      if (!pend) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          valid_paralelo_32 = 1'b1;
          data_paralelo_32 = $urandom;
        end else begin
          valid_paralelo_32 = 1'b0;
        end
      end
      if (valid_paralelo_32 && ready_mux_32_8) begin
        sent_q.push_back(data_paralelo_32);
        sent++;
        pend = 1'b0;
      end else begin
        pend = valid_paralelo_32;
      end
      tick();
      if (valid_mux_32_8) begin
        asm = {asm[23:0], data_mux_32_8};
        nb++;
        if (nb == 4) begin
          nb = 0;
          rcvd++;
          n_tests++;
          if (sent_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_word%0d: got %h, want nothing", rcvd - 1, asm);
          end else begin
            e = sent_q.pop_front();
            if (asm !== e) begin
              n_fail++;
              $display("FAIL sb_word%0d: got %h, want %h", rcvd - 1, asm, e);
            end
          end
        end
      end
      cyc++;
    end
    valid_paralelo_32 = 1'b0;
    n_tests++;
    if (rcvd != 1000 || sent_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_timeout: received=%0d pending=%0d after %0d cycles, want 1000/0",
               rcvd, sent_q.size(), cyc);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    reset = 1'b0;
    valid_paralelo_32 = 1'b0;
    data_paralelo_32 = '0;
    test_reset();
    test_single_word();
    tick();
    test_back_to_back();
    tick();
    test_backpressure();
    tick();
    test_mid_word_reset();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
